fft_frame_ctrl: RTL and testbench

//   Sequences one FFT frame at a time through the chain of fft_stage instances.
//   It accepts N input samples on a valid/ready stream and drives the shared stage enable and sample address.
//   It then flushes the pipeline with zeros and presents the N results on a valid/ready output stream.
//   The block sits between the sample source and the first stage, and between the last stage and the consumer.

---
 rtl/fft_frame_ctrl_if.sv | 41 ++++
 rtl/fft_frame_ctrl.sv | 114 +++++++++++
 tb/tb_fft_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: bundles the frame controller's streams and status.
//   start            frame request from the host
//   s_valid/s_ready  input sample stream, with s_real/s_imag
//   st_en/st_addr    shared stage enable and stage-0 sample address, with st_real/st_imag
//   pl_real/pl_imag  last-stage output, fed back into the controller
//   m_valid/m_ready  output stream, with m_real/m_imag/m_last
//   busy/done        frame status
// The slave modport is the controller's view; master is the surrounding system.
interface fft_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FFT_POINTS = 64
) ();
  logic                          start;
  logic                          s_valid;
  logic                          s_ready;
  logic [DATA_WIDTH-1:0]         s_real;
  logic [DATA_WIDTH-1:0]         s_imag;
  logic                          st_en;
  logic [DATA_WIDTH-1:0]         st_real;
  logic [DATA_WIDTH-1:0]         st_imag;
  logic [$clog2(FFT_POINTS)-1:0] st_addr;
  logic [DATA_WIDTH-1:0]         pl_real;
  logic [DATA_WIDTH-1:0]         pl_imag;
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         m_real;
  logic [DATA_WIDTH-1:0]         m_imag;
  logic                          m_last;
  logic                          busy;
  logic                          done;

  modport slave (
    input  start, s_valid, s_real, s_imag, pl_real, pl_imag, m_ready,
    output s_ready, st_en, st_real, st_imag, st_addr, m_valid, m_real, m_imag, m_last, busy, done
  );

  modport master (
    output start, s_valid, s_real, s_imag, pl_real, pl_imag, m_ready,
    input  s_ready, st_en, st_real, st_imag, st_addr, m_valid, m_real, m_imag, m_last, busy, done
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences one FFT frame through a chain of pipelined stages.
// Loads N samples from the input stream into stage 0, flushes the chain with zeros and
// presents the N last-stage results on the output stream.
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   io_bus  streams, stage controls and status (fft_frame_ctrl_if.slave)
module fft_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FFT_POINTS = 64,
  parameter int unsigned PIPE_LAT   = 70
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_frame_ctrl_if.slave io_bus
);
  localparam int unsigned AddrW = $clog2(FFT_POINTS);
  localparam int unsigned OutW  = AddrW + 1;
  localparam int unsigned EnW   = $clog2(PIPE_LAT + 1);

  localparam logic [AddrW-1:0] InLast   = AddrW'(FFT_POINTS - 1);
  localparam logic [OutW-1:0]  OutLast  = OutW'(FFT_POINTS - 1);
  localparam logic [OutW-1:0]  OutTotal = OutW'(FFT_POINTS);
  localparam logic [EnW-1:0]   EnSat    = EnW'(PIPE_LAT);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [AddrW-1:0] r_in_cnt, w_in_cnt_nxt;
  logic [OutW-1:0]  r_out_cnt, w_out_cnt_nxt;
  logic [EnW-1:0]   r_en_cnt, w_en_cnt_nxt;

  logic w_out_due;
  logic w_src_ok;
  logic w_st_en;
  logic w_m_valid;
  logic w_xfer;

  // Input and output share one enable: a result can only leave the chain on a cycle that
  // also advances it, so a stalled consumer stalls the source and vice versa.
  always_comb begin
    w_out_due = (r_en_cnt == EnSat) && (r_out_cnt < OutTotal);
    w_src_ok  = ((r_state == StLoad) && io_bus.s_valid) || (r_state == StFlush);
    w_st_en   = w_src_ok && (!w_out_due || io_bus.m_ready);
    w_m_valid = w_src_ok && w_out_due;
    w_xfer    = w_m_valid && io_bus.m_ready;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_in_cnt_nxt  = r_in_cnt;
    w_out_cnt_nxt = r_out_cnt;
    w_en_cnt_nxt  = r_en_cnt;

    if (w_st_en) begin
      w_in_cnt_nxt = r_in_cnt + 1'b1;  // wraps modulo N
      if (r_en_cnt != EnSat) begin
        w_en_cnt_nxt = r_en_cnt + 1'b1;
      end
    end
    if (w_xfer) begin
      w_out_cnt_nxt = r_out_cnt + 1'b1;
    end

    case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_nxt   = StLoad;
          w_in_cnt_nxt  = '0;
          w_out_cnt_nxt = '0;
          w_en_cnt_nxt  = '0;
        end
      end
      StLoad: begin
        if (w_st_en && (r_in_cnt == InLast)) begin
          w_state_nxt = StFlush;
        end
      end
      StFlush: begin
        if (w_xfer && (r_out_cnt == OutLast)) begin
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_en_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_cnt  <= w_in_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
      r_en_cnt  <= w_en_cnt_nxt;
    end
  end

  assign io_bus.s_ready = (r_state == StLoad) && (!w_out_due || io_bus.m_ready);
  assign io_bus.st_en   = w_st_en;
  // Zeros are fed during flush so the chain drains without stale data.
  assign io_bus.st_real = (r_state == StLoad) ? io_bus.s_real : {DATA_WIDTH{1'b0}};
  assign io_bus.st_imag = (r_state == StLoad) ? io_bus.s_imag : {DATA_WIDTH{1'b0}};
  assign io_bus.st_addr = r_in_cnt;
  assign io_bus.m_valid = w_m_valid;
  assign io_bus.m_real  = io_bus.pl_real;
  assign io_bus.m_imag  = io_bus.pl_imag;
  assign io_bus.m_last  = w_m_valid && (r_out_cnt == OutLast);
  assign io_bus.busy    = (r_state != StIdle);
  assign io_bus.done    = (r_state == StDone);
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench for fft_frame_ctrl.
// Instance a: N=64, PIPE_LAT=70. Instance b: N=16, PIPE_LAT=8.
// Each stage chain is modelled as an enabled delay line of PIPE_LAT entries.
module tb_fft_frame_ctrl;
  localparam int unsigned NA = 64;
  localparam int unsigned LA = 70;
  localparam int unsigned NB = 16;
  localparam int unsigned LB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.DATA_WIDTH(16), .FFT_POINTS(NA)) a_if ();
  fft_frame_ctrl_if #(.DATA_WIDTH(16), .FFT_POINTS(NB)) b_if ();

  fft_frame_ctrl #(.DATA_WIDTH(16), .FFT_POINTS(NA), .PIPE_LAT(LA)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (a_if)
  );

  fft_frame_ctrl #(.DATA_WIDTH(16), .FFT_POINTS(NB), .PIPE_LAT(LB)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (b_if)
  );

  logic [31:0] pipe_a [LA];
  logic [31:0] pipe_b [LB];

  always_ff @(posedge clk) begin
    if (a_if.st_en) begin
      for (int i = LA - 1; i > 0; i--) pipe_a[i] <= pipe_a[i-1];
      pipe_a[0] <= {a_if.st_real, a_if.st_imag};
    end
  end

  always_ff @(posedge clk) begin
    if (b_if.st_en) begin
      for (int i = LB - 1; i > 0; i--) pipe_b[i] <= pipe_b[i-1];
      pipe_b[0] <= {b_if.st_real, b_if.st_imag};
    end
  end

  assign a_if.pl_real = pipe_a[LA-1][31:16];
  assign a_if.pl_imag = pipe_a[LA-1][15:0];
  assign b_if.pl_real = pipe_b[LB-1][31:16];
  assign b_if.pl_imag = pipe_b[LB-1][15:0];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] smp_r(input int k, input bit imp);
    if (imp) return (k == 0) ? 16'h4000 : 16'h0000;
    return 16'(k * 37 + 5);
  endfunction

  function automatic logic [15:0] smp_i(input int k, input bit imp);
    if (imp) return 16'h0000;
    return 16'(65535 - k * 11);
  endfunction

  // Per-frame statistics for instance a
  int s_en, s_in, s_out, s_first_mv, s_addr_err, s_data_err, s_st_err;
  int s_last_cnt, s_last_at, s_done, s_done_gap, s_sready_drop, s_en_idle;
  int s_busy_end, s_timeout;

  task automatic run_a(input int vmode, input bit imp, input bit t4, input int abort_at);
    int  last_xfer_cyc;
    int  done_cyc;
    int  in_before;
    bit  prev_last;
    bit  sv;
    last_xfer_cyc = -10; done_cyc = -1; prev_last = 1'b0;
    s_en = 0; s_in = 0; s_out = 0; s_first_mv = -1; s_addr_err = 0; s_data_err = 0;
    s_st_err = 0; s_last_cnt = 0; s_last_at = -1; s_done = 0; s_done_gap = -1;
    s_sready_drop = 0; s_en_idle = 0; s_busy_end = -1; s_timeout = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (abort_at >= 0 && s_out == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val("t5_outputs_cleared",
                  {a_if.busy, a_if.done, a_if.st_en, a_if.s_ready, a_if.m_valid, a_if.m_last,
                   a_if.st_addr}, 0);
        check_val("t5_no_done_before_abort", s_done, 0);
        a_if.start = 1'b0;
        return;
      end
      sv = (vmode == 0) ? 1'b1 : (cyc % 2 == 1);
      a_if.start   = (cyc == 0) ||
                     (t4 && (s_in == 10 || (s_in == NA && s_out == 5) || prev_last));
      a_if.s_valid = sv;
      a_if.s_real  = smp_r(s_in, imp);
      a_if.s_imag  = smp_i(s_in, imp);
      a_if.m_ready = 1'b1;
      #1;
      in_before = s_in;
      if (a_if.st_en) begin
        if (a_if.st_addr != 6'(s_en % NA)) s_addr_err++;
        if (in_before >= NA && {a_if.st_real, a_if.st_imag} != 32'h0) s_st_err++;
        if (in_before < NA && {a_if.st_real, a_if.st_imag} != {a_if.s_real, a_if.s_imag})
          s_st_err++;
        s_en++;
      end
      if (cyc >= 1 && in_before < NA && !a_if.s_ready) s_sready_drop++;
      if (cyc >= 1 && in_before < NA && !sv && a_if.st_en) s_en_idle++;
      if (a_if.s_valid && a_if.s_ready) s_in++;
      prev_last = 1'b0;
      if (a_if.m_valid) begin
        if (s_first_mv < 0) s_first_mv = s_en;
        if ({a_if.m_real, a_if.m_imag} != {smp_r(s_out, imp), smp_i(s_out, imp)}) s_data_err++;
        if (a_if.m_last) begin
          s_last_cnt++;
          s_last_at = s_out;
        end
        if (a_if.m_ready) begin
          s_out++;
          last_xfer_cyc = cyc;
          prev_last = a_if.m_last;
        end
      end
      if (a_if.done) begin
        s_done++;
        s_done_gap = cyc - last_xfer_cyc;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        s_busy_end = a_if.busy;
        break;
      end
    end
    a_if.start = 1'b0;
    s_timeout = (done_cyc < 0) ? 1 : 0;
  endtask

  // Statistics for instance b
  int b_en, b_in, b_out, b_data_err, b_done, b_stall, b_stall_err, b_timeout;

  task automatic run_b();
    int done_cyc;
    done_cyc = -1;
    b_en = 0; b_in = 0; b_out = 0; b_data_err = 0; b_done = 0; b_stall = 0; b_stall_err = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      b_if.start   = (cyc == 0);
      b_if.s_valid = 1'b1;
      b_if.s_real  = smp_r(b_in, 1'b0);
      b_if.s_imag  = smp_i(b_in, 1'b0);
      b_if.m_ready = !(b_out == 3 && b_stall < 5);
      #1;
      if (!b_if.m_ready) begin
        b_stall++;
        if (!b_if.m_valid || b_if.s_ready || b_if.st_en ||
            {b_if.m_real, b_if.m_imag} != {smp_r(3, 1'b0), smp_i(3, 1'b0)}) b_stall_err++;
      end
      if (b_if.st_en) b_en++;
      if (b_if.s_valid && b_if.s_ready) b_in++;
      if (b_if.m_valid && b_if.m_ready) begin
        if ({b_if.m_real, b_if.m_imag} != {smp_r(b_out, 1'b0), smp_i(b_out, 1'b0)})
          b_data_err++;
        b_out++;
      end
      if (b_if.done) begin
        b_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
    end
    b_if.start = 1'b0;
    b_timeout = (done_cyc < 0) ? 1 : 0;
  endtask

  task automatic check_full_frame(input string tag);
    check_val({tag, "_timeout"}, s_timeout, 0);
    check_val({tag, "_en_cycles"}, s_en, 134);
    check_val({tag, "_inputs"}, s_in, 64);
    check_val({tag, "_outputs"}, s_out, 64);
    check_val({tag, "_first_mvalid_en"}, s_first_mv, 71);
    check_val({tag, "_data_err"}, s_data_err, 0);
    check_val({tag, "_last_at"}, s_last_at, 63);
    check_val({tag, "_last_cnt"}, s_last_cnt, 1);
    check_val({tag, "_done_cnt"}, s_done, 1);
    check_val({tag, "_done_gap"}, s_done_gap, 1);
    check_val({tag, "_busy_after"}, s_busy_end, 0);
  endtask

  int idle_bad;

  initial begin
    a_if.start = 1'b0; a_if.s_valid = 1'b1; a_if.s_real = 16'h1234; a_if.s_imag = 16'h5678;
    a_if.m_ready = 1'b1;
    b_if.start = 1'b0; b_if.s_valid = 1'b1; b_if.s_real = 16'h0; b_if.s_imag = 16'h0;
    b_if.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_a_outputs",
              {a_if.busy, a_if.done, a_if.st_en, a_if.s_ready, a_if.m_valid, a_if.m_last,
               a_if.st_addr, a_if.st_real, a_if.st_imag}, 0);
    check_val("rst_b_outputs",
              {b_if.busy, b_if.done, b_if.st_en, b_if.s_ready, b_if.m_valid, b_if.m_last,
               b_if.st_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("idle_no_accept", {a_if.busy, a_if.s_ready, a_if.st_en}, 0);

    // T1: free-running frame
    run_a(0, 1'b0, 1'b0, -1);
    check_full_frame("t1");
    check_val("t1_addr_err", s_addr_err, 0);
    check_val("t1_st_data_err", s_st_err, 0);

    // T2: input valid every other cycle
    run_a(1, 1'b0, 1'b0, -1);
    check_full_frame("t2");
    check_val("t2_sready_drop", s_sready_drop, 0);
    check_val("t2_en_without_valid", s_en_idle, 0);
    check_val("t2_addr_err", s_addr_err, 0);

    // T3: consumer stall on output 3, outputs overlap loading
    run_b();
    check_val("t3_timeout", b_timeout, 0);
    check_val("t3_stall_cycles", b_stall, 5);
    check_val("t3_stall_err", b_stall_err, 0);
    check_val("t3_inputs", b_in, 16);
    check_val("t3_outputs", b_out, 16);
    check_val("t3_en_cycles", b_en, 24);
    check_val("t3_data_err", b_data_err, 0);
    check_val("t3_done_cnt", b_done, 1);

    // T4: start pulses in LOAD, FLUSH and DONE, then a clean second frame
    run_a(0, 1'b0, 1'b1, -1);
    check_full_frame("t4a");
    run_a(0, 1'b0, 1'b0, -1);
    check_full_frame("t4b");

    // T5: reset during flush at output 20
    run_a(0, 1'b0, 1'b0, 20);
    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (a_if.done || a_if.busy || a_if.m_valid) idle_bad++;
    end
    check_val("t5_quiet_in_reset", idle_bad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(0, 1'b0, 1'b0, -1);
    check_full_frame("t5");

    // T6: impulse frame
    run_a(0, 1'b1, 1'b0, -1);
    check_full_frame("t6");
    check_val("t6_st_data_err", s_st_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
